// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add the START/WAIT_DONE handshake timeout.
module uart_tx_arbiter #(
  parameter int NREQ        = 2,
  parameter int IDX_W       = 1,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   req_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_clear_req,
  output logic [IDX_W-1:0]  owner,
  output logic              arb_busy,
  output logic              timeout_err
);

  if (NREQ < 2 || NREQ > 8 ||
      (2 ** IDX_W) < NREQ ||
      TIMEOUT_CYC < 2) begin : g_bad_param
    $error("uart_tx_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [NREQ-1:0]  ready_q, ready_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             clr_prev_q;
  logic             clr_rise;
  logic             tmo;
  logic             abort;

  logic             found;
  logic [IDX_W-1:0] win;
  logic [7:0]       win_data;
  int               idx;

  // First valid requester after last_grant, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found &&
          |(req_valid & (NREQ'(1) << idx))) begin
        found    = 1'b1;
        win      = IDX_W'(idx);
        win_data = 8'(req_data >> (8 * idx));
      end
    end
  end

  assign clr_rise = tx_clear_req & ~clr_prev_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    last_d    = last_q;
    ready_d   = '0;
    done_d    = '0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = START;
          tx_data_d = win_data;
          owner_d   = win;
          ready_d   = NREQ'(1) << win;
        end
      end
      START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (clr_rise) begin
          state_d = RELEASE;
          done_d  = NREQ'(1) << owner_q;
          last_d  = owner_q;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      RELEASE: begin
        if (!tx_clear_req && !tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = RELEASE;
      done_d  = NREQ'(1) << owner_q;
      last_d  = owner_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      owner_q    <= '0;
      last_q     <= IDX_W'(NREQ - 1);
      ready_q    <= '0;
      done_q     <= '0;
      clr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      clr_prev_q <= tx_clear_req;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [31:0] TmoLast =
    32'(TIMEOUT_CYC - 1);

  logic [31:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;

  // Restarts on every state change, so it measures time in the current state.
  always_comb begin
    cnt_d  = cnt_q + 32'd1;
    if (state_d != state_q) begin
      cnt_d = '0;
    end
    terr_d = terr_q | abort;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign tmo         = (cnt_q == TmoLast);
  assign timeout_err = terr_q;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign tx_start  = (state_q == START);
  assign arb_busy  = (state_q != IDLE);
  assign tx_data   = tx_data_q;
  assign owner     = owner_q;
  assign req_ready = ready_q;
  assign req_done  = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: transaction-level round-robin
// model, randomized byte traffic and a randomized transmitter emulator.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 3;
  localparam int IDX_W = 2;
  localparam int TMO   = 100;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_done;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_clear_req;
  logic [IDX_W-1:0]  owner;
  logic              arb_busy;
  logic              timeout_err;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .IDX_W(IDX_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .req_done(req_done),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_clear_req(tx_clear_req),
    .owner(owner),
    .arb_busy(arb_busy),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  int         checks;
  int         failures;
  int         done_cnt;
  int         tgt_done;
  int         mlast;
  bit         emu_en;
  bit         emu_idle;
  bit         pending;
  int         cur;
  exp_t       exp_q[$];
  logic [7:0] sd[NREQ][$];
  logic [7:0] bq[NREQ][$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // Move staged bytes to the requesters and predict the grant order.
  task automatic submit();
    int   rem[NREQ];
    int   pos[NREQ];
    int   tot;
    int   idx;
    bit   got;
    exp_t e;
    tot = 0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = sd[i].size();
      pos[i] = 0;
      tot += rem[i];
      foreach (sd[i][j]) bq[i].push_back(sd[i][j]);
    end
    tgt_done += tot;
    while (tot > 0) begin
      got = 1'b0;
      for (int k = 1; k <= NREQ && !got; k++) begin
        idx = (mlast + k) % NREQ;
        if (rem[idx] > 0) begin
          got    = 1'b1;
          e.idx  = idx;
          e.data = sd[idx][pos[idx]];
          exp_q.push_back(e);
          pos[idx]++;
          rem[idx]--;
          tot--;
          mlast = idx;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) sd[i].delete();
  endtask

  task automatic wait_all(input string nm);
    int n;
    n = 0;
    while ((done_cnt != tgt_done || exp_q.size() != 0)
           && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(nm, done_cnt, tgt_done);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(emu_idle && !arb_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle", {31'd0, arb_busy}, 0);
  endtask

  task automatic wait_start(input logic lvl,
                            input string nm);
    int n;
    n = 0;
    while (tx_start !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, tx_start}, {31'd0, lvl});
  endtask

  task automatic rst_begin();
    rst          = 1'b1;
    tx_busy      = 1'b0;
    tx_clear_req = 1'b0;
    emu_en       = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bq[i].delete();
      sd[i].delete();
    end
    exp_q.delete();
    mlast = NREQ - 1;
  endtask

  task automatic rst_end();
    tgt_done = done_cnt;
    rst      = 1'b0;
  endtask

  task automatic rand_round();
    int tot;
    int n;
    int r;
    tot = 0;
    for (int i = 0; i < NREQ; i++) begin
      n = int'($urandom_range(0, 3));
      repeat (n) sd[i].push_back(8'($urandom));
      tot += n;
    end
    if (tot == 0) begin
      r = int'($urandom_range(0, NREQ - 1));
      sd[r].push_back(8'($urandom));
    end
    submit();
    wait_all("round_done");
  endtask

  // Requesters: present queue head, advance when req_ready is seen.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && bq[i].size() > 0)
          void'(bq[i].pop_front());
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (bq[i].size() > 0);
        req_data[8*i +: 8] =
          (bq[i].size() > 0) ? bq[i][0] : 8'h00;
      end
    end
  end

  // Transmitter emulator with random handshake timing.
  initial begin
    int  n;
    bit  ovl;
    emu_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (emu_en && tx_start && !rst) begin
        emu_idle = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        tx_busy = 1'b1;
        n = 0;
        while (tx_start && n < 100) begin
          @(negedge clk);
          n++;
        end
        ovl = tx_start;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (tx_start) ovl = 1'b1;
        end
        tx_clear_req = 1'b1;
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          if (tx_start) ovl = 1'b1;
        end
        tx_busy = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (tx_start) ovl = 1'b1;
        end
        tx_clear_req = 1'b0;
        check("no_overlap", {31'd0, ovl}, 0);
        emu_idle = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every grant, tracks completions.
  initial begin
    exp_t e;
    pending = 1'b0;
    cur     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (req_ready != 0 || req_done != 0)
          check("rdy_done_excl",
                {31'd0, (req_ready != 0 && req_done != 0)}, 0);
        if (req_ready != 0) begin
          if (exp_q.size() == 0) begin
            check("ready_unexpected", 32'(req_ready), 0);
          end else begin
            e = exp_q.pop_front();
            check("ready_idx", 32'(req_ready),
                  32'(1) << e.idx);
            check("tx_data", 32'(tx_data), 32'(e.data));
            check("owner", 32'(owner), e.idx);
            check("ready_while_pending",
                  {31'd0, pending}, 0);
            pending = 1'b1;
            cur     = e.idx;
          end
        end
        if (req_done != 0) begin
          check("done_idx", 32'(req_done), 32'(1) << cur);
          check("done_pending", {31'd0, pending}, 1);
          pending = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #800000;
    check("watchdog", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    int  d0;
    int  n;
    bit  ovl;
    checks       = 0;
    failures     = 0;
    done_cnt     = 0;
    tgt_done     = 0;
    emu_en       = 1'b0;
    tx_busy      = 1'b0;
    tx_clear_req = 1'b0;
    rst_begin();
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_done", 32'(req_done), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_arb_busy", {31'd0, arb_busy}, 0);
    check("rst_tmo_err", {31'd0, timeout_err}, 0);
    rst_end();
    @(negedge clk);

    // Single byte, handshake driven by hand.
    sd[0].push_back(8'h55);
    submit();
    @(negedge clk);
    check("t1_start_early", {31'd0, tx_start}, 0);
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_start", {31'd0, tx_start}, 1);
    check("t1_data", 32'(tx_data), 32'h55);
    repeat (3) @(negedge clk);
    check("t1_start_held", {31'd0, tx_start}, 1);
    check("t1_ready_pulse", 32'(req_ready), 0);
    tx_busy = 1'b1;
    @(negedge clk);
    check("t1_start_drop", {31'd0, tx_start}, 0);
    tx_clear_req = 1'b1;
    @(negedge clk);
    check("t1_done", 32'(req_done), 32'h1);
    tx_clear_req = 1'b0;
    tx_busy      = 1'b0;
    @(negedge clk);
    check("t1_done_pulse", 32'(req_done), 0);
    repeat (4) @(negedge clk);
    check("t1_idle", {31'd0, arb_busy}, 0);
    check("t1_done_once", done_cnt, tgt_done);

    // Two requesters continuously valid after reset.
    rst_begin();
    repeat (2) @(negedge clk);
    rst_end();
    sd[0].push_back(8'hA0);
    sd[0].push_back(8'hA0);
    sd[1].push_back(8'hB1);
    sd[1].push_back(8'hB1);
    emu_en = 1'b1;
    submit();
    wait_all("alt_done");

    for (int r = 0; r < 20; r++) rand_round();
    wait_idle();
    emu_en = 1'b0;

    // tx_busy and tx_clear_req together in START.
    sd[1].push_back(8'h3C);
    submit();
    wait_start(1'b1, "bc_start");
    tx_busy      = 1'b1;
    tx_clear_req = 1'b1;
    @(negedge clk);
    check("bc_start_drop", {31'd0, tx_start}, 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    check("bc_no_done", done_cnt, d0);
    tx_clear_req = 1'b0;
    @(negedge clk);
    tx_clear_req = 1'b1;
    repeat (2) @(negedge clk);
    check("bc_done", done_cnt, d0 + 1);
    tx_clear_req = 1'b0;
    tx_busy      = 1'b0;
    wait_idle();

    // Long clear level: one completion, no overlapping start.
    sd[2].push_back(8'h7E);
    submit();
    wait_start(1'b1, "lc_start");
    tx_busy = 1'b1;
    @(negedge clk);
    tx_clear_req = 1'b1;
    sd[0].push_back(8'h81);
    submit();
    d0  = done_cnt;
    ovl = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (tx_start) ovl = 1'b1;
    end
    check("lc_one_done", done_cnt, d0 + 1);
    tx_clear_req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_start) ovl = 1'b1;
    end
    check("lc_no_start", {31'd0, ovl}, 0);
    tx_busy = 1'b0;
    emu_en  = 1'b1;
    wait_all("lc_next");

    // Reset while in WAIT_DONE after serving requester 1.
    sd[1].push_back(8'h11);
    submit();
    wait_all("pre_rst");
    wait_idle();
    emu_en = 1'b0;
    sd[1].push_back(8'h22);
    submit();
    wait_start(1'b1, "rw_start");
    tx_busy = 1'b1;
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    rst_begin();
    @(negedge clk);
    check("rw_tx_start", {31'd0, tx_start}, 0);
    check("rw_arb_busy", {31'd0, arb_busy}, 0);
    check("rw_no_done", 32'(req_done), 0);
    rst_end();
    @(negedge clk);
    check("rw_done_cnt", done_cnt, d0);
    for (int i = 0; i < NREQ; i++)
      sd[i].push_back(8'($urandom));
    emu_en = 1'b1;
    submit();
    wait_all("rw_after");
    wait_idle();
    emu_en = 1'b0;

    // Transmitter never answers.
    sd[1].push_back(8'h99);
    submit();
    d0 = done_cnt;
    wait_start(1'b1, "to_start");
    n = 1;
`ifdef UART_ARB_TIMEOUT_EN
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (!tx_start) break;
      n++;
    end
    check("to_start_cycles", n, TMO);
    check("to_err", {31'd0, timeout_err}, 1);
    @(negedge clk);
    check("to_one_done", done_cnt, d0 + 1);
    emu_en = 1'b1;
    rand_round();
    check("to_err_sticky", {31'd0, timeout_err}, 1);
`else
    for (int j = 0; j < 9999; j++) begin
      @(negedge clk);
      if (tx_start) n++;
    end
    check("nt_start_held", n, 10000);
    check("nt_err", {31'd0, timeout_err}, 0);
    check("nt_no_done", done_cnt, d0);
    emu_en = 1'b1;
    wait_all("nt_finish");
    rand_round();
`endif

    for (int r = 0; r < 8; r++) rand_round();
    wait_idle();
    check("final_queue", exp_q.size(), 0);
    check("final_done", done_cnt, tgt_done);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
